// File: rtl/uart_sw_loader.sv
// Framed UART software loader: hunts for a sync byte, collects address and length,
// writes payload bytes into RAM byte lanes, then answers the checksum with ACK or NAK.
module uart_sw_loader #(
    parameter int         ADDR_LEN    = 14,
    parameter int         XLEN        = 32,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 1000000
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  sw_uart_upgrade_b,
    input  logic                  uart_rx_valid,
    input  logic [7:0]            uart_rx_data,
    output logic                  during_sw_upgrade,
    output logic                  uart_ram_wr_en,
    output logic [XLEN-1:0]       uart_ram_wr_data,
    output logic [ADDR_LEN-1:0]   uart_ram_addr,
    output logic [XLEN/8-1:0]     uart_ram_we,
    output logic                  upgrade_done,
    output logic                  upgrade_err,
    output logic                  ack_valid,
    output logic [7:0]            ack_data
);
    localparam int NB = XLEN / 8;
    localparam int LB = $clog2(NB);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SYNC = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_LEN  = 3'd3;
    localparam logic [2:0] S_DATA = 3'd4;
    localparam logic [2:0] S_CSUM = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;
    localparam logic [2:0] S_ERR  = 3'd7;

    localparam logic [7:0]  ACK     = 8'h06;
    localparam logic [7:0]  NAK     = 8'h15;
    localparam bit          TO_EN   = (TIMEOUT_CYC != 0);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC) - 32'd1;

    logic [2:0]          state;
    logic [1:0]          fcnt;
    logic [31:0]         shift_sr;
    logic [ADDR_LEN-1:0] base;
    logic [31:0]         len;
    logic [31:0]         idx;
    logic [7:0]          csum;
    logic [31:0]         tcnt;

    logic [31:0] sr_next;
    logic [LB-1:0] lane;
    logic in_frame;

    // Address and length arrive little-endian, so each new byte enters at the top.
    assign sr_next  = {uart_rx_data, shift_sr[31:8]};
    assign lane     = idx[LB-1:0];
    assign in_frame = (state == S_ADDR) || (state == S_LEN) ||
                      (state == S_DATA) || (state == S_CSUM);

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state             <= S_IDLE;
            fcnt              <= '0;
            shift_sr          <= '0;
            base              <= '0;
            len               <= '0;
            idx               <= '0;
            csum              <= '0;
            tcnt              <= '0;
            during_sw_upgrade <= 1'b0;
            uart_ram_wr_en    <= 1'b0;
            uart_ram_wr_data  <= '0;
            uart_ram_addr     <= '0;
            uart_ram_we       <= '0;
            upgrade_done      <= 1'b0;
            upgrade_err       <= 1'b0;
            ack_valid         <= 1'b0;
            ack_data          <= '0;
        end else begin
            uart_ram_wr_en <= 1'b0;
            ack_valid      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!sw_uart_upgrade_b) begin
                        during_sw_upgrade <= 1'b1;
                        state             <= S_SYNC;
                    end
                end
                S_SYNC, S_DONE, S_ERR: begin
                    if (uart_rx_valid && uart_rx_data == SYNC_BYTE) begin
                        upgrade_done <= 1'b0;
                        upgrade_err  <= 1'b0;
                        csum         <= '0;
                        fcnt         <= '0;
                        idx          <= '0;
                        tcnt         <= '0;
                        state        <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (uart_rx_valid) begin
                        shift_sr <= sr_next;
                        fcnt     <= fcnt + 2'd1;
                        if (fcnt == 2'd3) begin
                            base  <= sr_next[ADDR_LEN-1:0];
                            state <= S_LEN;
                        end
                    end
                end
                S_LEN: begin
                    if (uart_rx_valid) begin
                        shift_sr <= sr_next;
                        fcnt     <= fcnt + 2'd1;
                        if (fcnt == 2'd3) begin
                            len   <= sr_next;
                            idx   <= '0;
                            state <= (sr_next == 32'd0) ? S_CSUM : S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (uart_rx_valid) begin
                        uart_ram_wr_en   <= 1'b1;
                        uart_ram_addr    <= base + ADDR_LEN'(idx >> LB);
                        uart_ram_we      <= NB'(1) << lane;
                        uart_ram_wr_data <= XLEN'(uart_rx_data) << {lane, 3'b000};
                        csum             <= csum + uart_rx_data;
                        idx              <= idx + 32'd1;
                        if (idx == len - 32'd1)
                            state <= S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (uart_rx_valid) begin
                        ack_valid <= 1'b1;
                        if (uart_rx_data == csum) begin
                            upgrade_done <= 1'b1;
                            ack_data     <= ACK;
                            state        <= S_DONE;
                        end else begin
                            upgrade_err <= 1'b1;
                            ack_data    <= NAK;
                            state       <= S_ERR;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Inter-byte watchdog overrides the state decode only on an idle cycle.
            if (uart_rx_valid) begin
                tcnt <= '0;
            end else if (TO_EN && in_frame) begin
                if (tcnt == TO_LAST) begin
                    tcnt         <= '0;
                    upgrade_err  <= 1'b1;
                    upgrade_done <= 1'b0;
                    ack_valid    <= 1'b1;
                    ack_data     <= NAK;
                    state        <= S_ERR;
                end else begin
                    tcnt <= tcnt + 32'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_sw_loader.sv
// Directed bench for uart_sw_loader: framing, lane writes, checksum ACK/NAK,
// address wrap, inter-byte timeout, sync hunting and mid-frame reset.
module tb_uart_sw_loader;
    logic        clk = 1'b0;
    logic        rstb;
    logic        sw_uart_upgrade_b;
    logic        uart_rx_valid;
    logic [7:0]  uart_rx_data;
    logic        during_sw_upgrade;
    logic        uart_ram_wr_en;
    logic [31:0] uart_ram_wr_data;
    logic [13:0] uart_ram_addr;
    logic [3:0]  uart_ram_we;
    logic        upgrade_done;
    logic        upgrade_err;
    logic        ack_valid;
    logic [7:0]  ack_data;

    int checks = 0;
    int errors = 0;
    int wr_pulses = 0;

    uart_sw_loader #(
        .ADDR_LEN(14), .XLEN(32), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(100)
    ) dut (
        .clk(clk), .rstb(rstb), .sw_uart_upgrade_b(sw_uart_upgrade_b),
        .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data),
        .during_sw_upgrade(during_sw_upgrade), .uart_ram_wr_en(uart_ram_wr_en),
        .uart_ram_wr_data(uart_ram_wr_data), .uart_ram_addr(uart_ram_addr),
        .uart_ram_we(uart_ram_we), .upgrade_done(upgrade_done),
        .upgrade_err(upgrade_err), .ack_valid(ack_valid), .ack_data(ack_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (uart_ram_wr_en) wr_pulses++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte was sampled.
    task automatic send(input logic [7:0] b);
        uart_rx_valid = 1'b1;
        uart_rx_data  = b;
        @(negedge clk);
        uart_rx_valid = 1'b0;
    endtask

    task automatic send_wr(input logic [7:0] b, input logic [13:0] a,
                           input logic [3:0] we, input logic [31:0] d);
        send(b);
        chk("wr_en", 64'(uart_ram_wr_en), 64'd1);
        chk("wr_addr", 64'(uart_ram_addr), 64'(a));
        chk("wr_we", 64'(uart_ram_we), 64'(we));
        chk("wr_data", 64'(uart_ram_wr_data), 64'(d));
    endtask

    task automatic hdr(input logic [31:0] a, input logic [31:0] n);
        send(8'hA5);
        chk("sync_clears_done", 64'(upgrade_done), 64'd0);
        chk("sync_clears_err", 64'(upgrade_err), 64'd0);
        for (int k = 0; k < 4; k++) send(a[8*k +: 8]);
        for (int k = 0; k < 4; k++) send(n[8*k +: 8]);
        chk("hdr_no_write", 64'(uart_ram_wr_en), 64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_during"}, 64'(during_sw_upgrade), 64'd0);
        chk({tag, "_wr_en"}, 64'(uart_ram_wr_en), 64'd0);
        chk({tag, "_wr_data"}, 64'(uart_ram_wr_data), 64'd0);
        chk({tag, "_addr"}, 64'(uart_ram_addr), 64'd0);
        chk({tag, "_we"}, 64'(uart_ram_we), 64'd0);
        chk({tag, "_done"}, 64'(upgrade_done), 64'd0);
        chk({tag, "_err"}, 64'(upgrade_err), 64'd0);
        chk({tag, "_ack_valid"}, 64'(ack_valid), 64'd0);
        chk({tag, "_ack_data"}, 64'(ack_data), 64'd0);
    endtask

    initial begin
        int p;
        int n;
        rstb = 1'b0;
        sw_uart_upgrade_b = 1'b1;
        uart_rx_valid = 1'b0;
        uart_rx_data = 8'h00;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rstb = 1'b1;

        // Bytes in IDLE are ignored and do not start upgrade mode
        send(8'hA5);
        chk("idle_ignores", 64'(during_sw_upgrade), 64'd0);
        sw_uart_upgrade_b = 1'b0;
        @(negedge clk);
        chk("during_set", 64'(during_sw_upgrade), 64'd1);
        sw_uart_upgrade_b = 1'b1;

        // Sync hunting: stray bytes do nothing
        send(8'h00);
        send(8'hFF);
        chk("stray_no_write", 64'(wr_pulses), 64'd0);

        // Frame 1: good checksum 0x75
        hdr(32'h10, 32'd6);
        send_wr(8'h11, 14'h10, 4'b0001, 32'h0000_0011);
        send_wr(8'h12, 14'h10, 4'b0010, 32'h0000_1200);
        send_wr(8'h13, 14'h10, 4'b0100, 32'h0013_0000);
        send_wr(8'h14, 14'h10, 4'b1000, 32'h1400_0000);
        send_wr(8'h15, 14'h11, 4'b0001, 32'h0000_0015);
        send_wr(8'h16, 14'h11, 4'b0010, 32'h0000_1600);
        send(8'h75);
        chk("f1_wr_en_off", 64'(uart_ram_wr_en), 64'd0);
        chk("f1_ack_valid", 64'(ack_valid), 64'd1);
        chk("f1_ack_data", 64'(ack_data), 64'h06);
        chk("f1_done", 64'(upgrade_done), 64'd1);
        chk("f1_err", 64'(upgrade_err), 64'd0);
        @(negedge clk);
        chk("f1_ack_pulse_end", 64'(ack_valid), 64'd0);
        chk("f1_ack_hold", 64'(ack_data), 64'h06);
        chk("f1_addr_hold", 64'(uart_ram_addr), 64'h11);
        chk("f1_we_hold", 64'(uart_ram_we), 64'b0010);
        chk("f1_data_hold", 64'(uart_ram_wr_data), 64'h1600);

        // Frame 2: bad checksum, writes still happen
        p = wr_pulses;
        hdr(32'h10, 32'd6);
        send_wr(8'h11, 14'h10, 4'b0001, 32'h0000_0011);
        send_wr(8'h12, 14'h10, 4'b0010, 32'h0000_1200);
        send_wr(8'h13, 14'h10, 4'b0100, 32'h0013_0000);
        send_wr(8'h14, 14'h10, 4'b1000, 32'h1400_0000);
        send_wr(8'h15, 14'h11, 4'b0001, 32'h0000_0015);
        send_wr(8'h16, 14'h11, 4'b0010, 32'h0000_1600);
        send(8'h74);
        chk("f2_writes", 64'(wr_pulses - p), 64'd6);
        chk("f2_ack_valid", 64'(ack_valid), 64'd1);
        chk("f2_nak", 64'(ack_data), 64'h15);
        chk("f2_err", 64'(upgrade_err), 64'd1);
        chk("f2_done", 64'(upgrade_done), 64'd0);

        // Zero-length frame
        p = wr_pulses;
        hdr(32'h0, 32'h0);
        send(8'h00);
        chk("z_no_write", 64'(wr_pulses - p), 64'd0);
        chk("z_ack_valid", 64'(ack_valid), 64'd1);
        chk("z_ack", 64'(ack_data), 64'h06);
        chk("z_done", 64'(upgrade_done), 64'd1);

        // Address wrap: upper address bits discarded, base 0x3FFF
        hdr(32'h8000_FFFF, 32'd8);
        for (int i = 0; i < 8; i++)
            send_wr(8'(i + 1), 14'((14'h3FFF + 14'(i / 4)) & 14'h3FFF),
                    4'(1 << (i % 4)), 32'((i + 1) << (8 * (i % 4))));
        send(8'h24);
        chk("wrap_ack", 64'(ack_data), 64'h06);
        chk("wrap_done", 64'(upgrade_done), 64'd1);
        repeat (150) @(negedge clk);
        chk("done_no_timeout", 64'(upgrade_done), 64'd1);
        chk("done_no_timeout_err", 64'(upgrade_err), 64'd0);

        // Timeout after two address bytes
        send(8'hA5);
        send(8'h01);
        send(8'h02);
        n = 0;
        while (!upgrade_err && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("to_cycles", 64'(n), 64'd100);
        chk("to_ack_valid", 64'(ack_valid), 64'd1);
        chk("to_nak", 64'(ack_data), 64'h15);
        chk("to_done", 64'(upgrade_done), 64'd0);

        // Recovery frame
        hdr(32'h20, 32'd1);
        send_wr(8'h5A, 14'h20, 4'b0001, 32'h0000_005A);
        send(8'h5A);
        chk("rec_ack", 64'(ack_data), 64'h06);
        chk("rec_done", 64'(upgrade_done), 64'd1);
        chk("rec_err", 64'(upgrade_err), 64'd0);

        // Reset in the middle of DATA
        hdr(32'h30, 32'd8);
        send_wr(8'h01, 14'h30, 4'b0001, 32'h0000_0001);
        send_wr(8'h02, 14'h30, 4'b0010, 32'h0000_0200);
        rstb = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
        chk_all_zero("midrst");
        p = wr_pulses;
        send(8'h03);
        send(8'h04);
        @(negedge clk);
        chk("midrst_no_write", 64'(wr_pulses - p), 64'd0);
        chk("midrst_idle", 64'(during_sw_upgrade), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
